// File: rtl/uart_pkg.sv
// UART TX shared types: FSM state enum, baud-select codes, divisor helper.
// No latency (types/constants only); no handshake involved.
// UART_TX_PARITY_EN adds the PARITY state to the enum.
package uart_pkg;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } tx_state_t;
`endif

  localparam logic [2:0] BAUD_300    = 3'd0;
  localparam logic [2:0] BAUD_1200   = 3'd1;
  localparam logic [2:0] BAUD_2400   = 3'd2;
  localparam logic [2:0] BAUD_4800   = 3'd3;
  localparam logic [2:0] BAUD_9600   = 3'd4;
  localparam logic [2:0] BAUD_19200  = 3'd5;
  localparam logic [2:0] BAUD_115200 = 3'd6;

  // Clocks per bit, rounded to nearest; codes 6 and 7 both select 115200.
  function automatic int unsigned baud_div(input int unsigned clk_hz, input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      BAUD_300:   baud = 300;
      BAUD_1200:  baud = 1200;
      BAUD_2400:  baud = 2400;
      BAUD_4800:  baud = 4800;
      BAUD_9600:  baud = 9600;
      BAUD_19200: baud = 19200;
      default:    baud = 115200;
    endcase
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: loadable divisor, counts 0..div-1 while enabled.
// bit_end is combinational in the cycle the count sits at div-1.
// No handshake; load has priority over clear, clear over counting.
module uart_baud_gen #(
  parameter int DIV_W = 21
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div_in,
  input  logic             en,
  input  logic             clr,
  output logic             bit_end
);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;

  assign bit_end = en && (cnt_q == (div_q - DIV_W'(1)));

  // Divisor latch and free-running bit counter that wraps at div-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= div_in;
      cnt_q <= '0;
    end else if (clr || bit_end) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start, DATA_W bits LSB first, optional parity (UART_TX_PARITY_EN), 1/2 stop.
// Line goes low on the accept edge; frame lasts (1+DATA_W+P+S)*DIV clocks to the tx_done pulse.
// tx_ready only in IDLE (includes the tx_done cycle); no skid, producer holds tx_valid.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int DATA_W = 8,
  parameter int DIV_W  = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        baud_set,
  input  logic              stop2,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              uart_tx,
  output logic              tx_busy,
  output logic              tx_done
`ifdef UART_TX_PARITY_EN
  ,
  input  logic              parity_en,
  input  logic              parity_odd
`endif
);

  localparam int IDX_W = $clog2(DATA_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  tx_state_t         state;
  tx_state_t         state_nxt;
  logic [DATA_W-1:0] sh_q;
  logic [IDX_W-1:0]  idx_q;
  logic              stop2_q;
  logic              stop_idx_q;
  logic              accept;
  logic              bit_end;
  logic              line_nxt;
  logic              done_nxt;
  logic [DIV_W-1:0]  div_sel;
`ifdef UART_TX_PARITY_EN
  logic              par_en_q;
  logic              par_bit_q;
`endif

  assign tx_ready = (state == ST_IDLE);
  assign tx_busy  = !tx_ready;
  assign accept   = tx_valid && tx_ready;
  assign div_sel  = DIV_W'(baud_div(CLK_HZ, baud_set));

  uart_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (accept),
    .div_in  (div_sel),
    .en      (tx_busy),
    .clr     (tx_ready),
    .bit_end (bit_end)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state: every non-idle state advances only on a bit-period wrap.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept)  state_nxt = ST_START;
      ST_START: if (bit_end) state_nxt = ST_DATA;
      ST_DATA: begin
        if (bit_end && (idx_q == LAST_IDX)) begin
`ifdef UART_TX_PARITY_EN
          state_nxt = par_en_q ? ST_PARITY : ST_STOP;
`else
          state_nxt = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: if (bit_end) state_nxt = ST_STOP;
`endif
      ST_STOP:  if (bit_end && (stop_idx_q || !stop2_q)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Output decode: level the line must hold after this edge, plus done on final stop wrap.
  always_comb begin
    line_nxt = 1'b1;
    done_nxt = 1'b0;
    case (state)
      ST_IDLE:  line_nxt = !accept;
      ST_START: line_nxt = bit_end ? sh_q[0] : 1'b0;
      ST_DATA: begin
        if (!bit_end) begin
          line_nxt = sh_q[0];
        end else if (idx_q != LAST_IDX) begin
          line_nxt = sh_q[1];
`ifdef UART_TX_PARITY_EN
        end else if (par_en_q) begin
          line_nxt = par_bit_q;
`endif
        end else begin
          line_nxt = 1'b1;
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: line_nxt = bit_end ? 1'b1 : par_bit_q;
`endif
      ST_STOP: begin
        line_nxt = 1'b1;
        done_nxt = (state_nxt == ST_IDLE);
      end
      default: line_nxt = 1'b1;
    endcase
  end

  // Frame datapath: latch everything at accept so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_q       <= '0;
      idx_q      <= '0;
      stop2_q    <= 1'b0;
      stop_idx_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else if (accept) begin
      sh_q       <= tx_data;
      idx_q      <= '0;
      stop2_q    <= stop2;
      stop_idx_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= parity_en;
      par_bit_q  <= (^tx_data) ^ parity_odd;
`endif
    end else if (bit_end) begin
      if (state == ST_DATA) begin
        sh_q  <= sh_q >> 1;
        idx_q <= idx_q + IDX_W'(1);
      end
      if (state == ST_STOP) stop_idx_q <= 1'b1;
    end
  end

  // Registered line and done strobe; reset drives the line idle high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      uart_tx <= line_nxt;
      tx_done <= done_nxt;
    end
  end

endmodule
